// File: rtl/lead_one_scanner.sv
// lead_one_scanner
//   Multi-cycle leading/trailing-one scanner for a WIDTH-bit fixed-point
//   vector. Examines CHUNK bits per cycle, starting at the top chunk
//   (MSB mode) or the bottom chunk (LSB mode), and stops on the first hit.
//   Reports the bit index, the exponent relative to the binary point, and
//   the half exponent ceil(exp/2) that seeds the sqrt/normalise units.
//
// Ports
//   clk       in   clock, rising edge
//   rst_      in   synchronous active-high reset
//   start     in   request, accepted when ready=1
//   vec       in   [WIDTH-1:0] operand, captured on accept
//   mode_lsb  in   0 = highest set bit, 1 = lowest set bit
//   ready     out  high while idle (including the done cycle)
//   done      out  one-cycle pulse when results update
//   zero      out  operand had no set bit
//   idx       out  [LOC_W-1:0] bit index of the hit
//   exp       out  signed [LOC_W:0] idx - FRAC_BITS
//   half_exp  out  signed [LOC_W:0] (exp+1)>>>1
module lead_one_scanner #(
  parameter int WIDTH     = 52,
  parameter int FRAC_BITS = 4,
  parameter int CHUNK     = 8,
  localparam int LOC_W    = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    start,
  input  logic [WIDTH-1:0]        vec,
  input  logic                    mode_lsb,
  output logic                    ready,
  output logic                    done,
  output logic                    zero,
  output logic [LOC_W-1:0]        idx,
  output logic signed [LOC_W:0]   exp,
  output logic signed [LOC_W:0]   half_exp
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int POS_W  = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  // One guard bit beyond the output width so exp+1 never wraps.
  localparam int EXT_W  = LOC_W + 2;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NCHUNK - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  // Exponent relative to the binary point.
  function automatic logic signed [LOC_W:0] to_exp(input logic [LOC_W-1:0] i);
    logic signed [EXT_W-1:0] e;
    e = $signed({2'b00, i}) - EXT_W'(FRAC_BITS);
    return e[LOC_W:0];
  endfunction

  // ceil(e/2): add one then arithmetic shift, i.e. round toward +inf.
  function automatic logic signed [LOC_W:0] half_of(input logic signed [LOC_W:0] e);
    logic signed [EXT_W-1:0] t;
    t = EXT_W'(e) + EXT_W'(1);
    t = t >>> 1;
    return t[LOC_W:0];
  endfunction

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        vec_q, vec_d;
  logic                    mode_q, mode_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    done_q, done_d;
  logic                    zero_q, zero_d;
  logic [LOC_W-1:0]        idx_q, idx_d;
  logic signed [LOC_W:0]   exp_q, exp_d;
  logic signed [LOC_W:0]   half_q, half_d;

  logic [PAD_W-1:0]        vpad;
  logic [CHUNK-1:0]        chunk;
  logic                    hit;
  logic [POS_W-1:0]        pos;
  logic [LOC_W-1:0]        hit_idx;
  logic                    last;
  logic signed [LOC_W:0]   hit_exp;

  // Zero-extend so the partial top chunk reads its pad bits as 0.
  assign vpad  = PAD_W'(vec_q);
  assign chunk = vpad[ptr_q * CHUNK +: CHUNK];
  assign last  = mode_q ? (ptr_q == PTR_LAST) : (ptr_q == '0);

  // Priority encode the current chunk; the last assignment in loop order wins.
  always_comb begin
    int tmp;
    hit = 1'b0;
    pos = '0;
    if (mode_q) begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (chunk[i]) begin
          hit = 1'b1;
          pos = POS_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < CHUNK; i++) begin
        if (chunk[i]) begin
          hit = 1'b1;
          pos = POS_W'(i);
        end
      end
    end
    tmp     = int'(ptr_q) * CHUNK + int'(pos);
    hit_idx = LOC_W'(tmp);
    hit_exp = to_exp(hit_idx);
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    mode_d  = mode_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    half_d  = half_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = vec;
          mode_d  = mode_lsb;
          ptr_d   = mode_lsb ? '0 : PTR_LAST;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          idx_d   = hit_idx;
          exp_d   = hit_exp;
          half_d  = half_of(hit_exp);
          zero_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (last) begin
          idx_d   = '0;
          exp_d   = to_exp('0);
          half_d  = half_of(to_exp('0));
          zero_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ptr_d = mode_q ? ptr_q + PTR_W'(1) : ptr_q - PTR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
      exp_q   <= '0;
      half_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      half_q  <= half_d;
    end
  end

  // Operand and scan pointer; only meaningful while in SCAN
  always_ff @(posedge clk) begin
    vec_q  <= vec_d;
    mode_q <= mode_d;
    ptr_q  <= ptr_d;
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign zero     = zero_q;
  assign idx      = idx_q;
  assign exp      = exp_q;
  assign half_exp = half_q;

endmodule

// File: tb/tb_lead_one_scanner.sv
module tb_lead_one_scanner;

  localparam int WIDTH = 52;
  localparam int FRAC_BITS = 4;
  localparam int CHUNK = 8;
  localparam int LOC_W = 6;

  logic                  clk = 1'b0;
  logic                  rst_ = 1'b1;
  logic                  start = 1'b0;
  logic [WIDTH-1:0]      vec = '0;
  logic                  mode_lsb = 1'b0;
  logic                  ready, done, zero;
  logic [LOC_W-1:0]      idx;
  logic signed [LOC_W:0] exp, half_exp;

  lead_one_scanner #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_(rst_), .start(start), .vec(vec), .mode_lsb(mode_lsb),
    .ready(ready), .done(done), .zero(zero), .idx(idx), .exp(exp),
    .half_exp(half_exp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string nm;
    logic  z;
    int    ix;
    int    e;
    int    h;
    int    lat;
    int    acc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_ && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk({x.nm, "_zero"}, int'(zero), int'(x.z));
        chk({x.nm, "_idx"}, int'(idx), x.ix);
        chk({x.nm, "_exp"}, int'(exp), x.e);
        chk({x.nm, "_half"}, int'(half_exp), x.h);
        chk({x.nm, "_lat"}, cyc - x.acc, x.lat);
        chk({x.nm, "_ready"}, int'(ready), 1);
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] v, input logic m, input logic push_it,
                       input string nm, input logic z, input int ix, input int e,
                       input int h, input int lat);
    int guard;
    exp_t x;
    guard = 0;
    while (!ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready) begin
      chk({nm, "_ready_timeout"}, 0, 1);
      return;
    end
    start = 1'b1;
    vec = v;
    mode_lsb = m;
    @(posedge clk); #1;
    if (push_it) begin
      x.nm = nm; x.z = z; x.ix = ix; x.e = e; x.h = h; x.lat = lat; x.acc = cyc;
      q.push_back(x);
    end
    start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_ready"}, int'(ready), 1);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_zero"}, int'(zero), 0);
    chk({nm, "_idx"}, int'(idx), 0);
    chk({nm, "_exp"}, int'(exp), 0);
    chk({nm, "_half"}, int'(half_exp), 0);
  endtask

  initial begin
    #20000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] ones;
    ones = '1;
    rst_ = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst_ = 1'b0;

    // Single-hit vectors
    issue(52'h8_0000_0000_0000, 1'b0, 1'b1, "msb_b51",   1'b0, 51, 47, 24, 1);
    issue(52'h0_0000_0000_0080, 1'b0, 1'b1, "msb_0x80",  1'b0, 7, 3, 2, 7);
    issue(52'h0_0000_0000_0002, 1'b0, 1'b1, "msb_0x2",   1'b0, 1, -3, -1, 7);
    issue(52'h0_0000_0000_0001, 1'b0, 1'b1, "msb_0x1",   1'b0, 0, -4, -2, 7);
    issue(52'h1_0000_0000_0000, 1'b0, 1'b1, "msb_b48",   1'b0, 48, 44, 22, 1);
    issue(52'h8_0000_0000_0000, 1'b1, 1'b1, "lsb_b51",   1'b1 & 1'b0, 51, 47, 24, 7);
    // Two bits set: mode decides which one wins
    issue(52'h0_0100_0000_0008, 1'b1, 1'b1, "lsb_b3_40", 1'b0, 3, -1, 0, 1);
    issue(52'h0_0100_0000_0008, 1'b0, 1'b1, "msb_b3_40", 1'b0, 40, 36, 18, 2);
    issue(ones,                 1'b0, 1'b1, "msb_ones",  1'b0, 51, 47, 24, 1);
    issue(ones,                 1'b1, 1'b1, "lsb_ones",  1'b0, 0, -4, -2, 1);
    // Zero vector in both modes
    issue(52'h0,                1'b0, 1'b1, "msb_zero",  1'b1, 0, -4, -2, 7);
    issue(52'h0,                1'b1, 1'b1, "lsb_zero",  1'b1, 0, -4, -2, 7);
    drain();

    // start during SCAN must be ignored
    issue(52'h0_0000_0000_0080, 1'b0, 1'b1, "ign_first", 1'b0, 7, 3, 2, 7);
    start = 1'b1; vec = 52'h8_0000_0000_0000; mode_lsb = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0; vec = '0;
    // Back-to-back: second request lands in the done cycle of the first
    issue(52'h8_0000_0000_0000, 1'b0, 1'b1, "b2b_a", 1'b0, 51, 47, 24, 1);
    issue(52'h0_0100_0000_0008, 1'b1, 1'b1, "b2b_b", 1'b0, 3, -1, 0, 1);
    issue(52'h0_0100_0000_0008, 1'b0, 1'b1, "b2b_c", 1'b0, 40, 36, 18, 2);
    drain();

    // Reset mid-scan: no done, outputs cleared
    issue(52'h0, 1'b0, 1'b0, "abort", 1'b1, 0, -4, -2, 7);
    repeat (2) begin @(posedge clk); #1; end
    rst_ = 1'b1;
    @(posedge clk); #1;
    rst_ = 1'b0;
    chk_idle_zero("midreset");
    repeat (10) begin @(posedge clk); #1; end
    issue(52'h0_0000_0000_0002, 1'b0, 1'b1, "post_rst", 1'b0, 1, -3, -1, 7);
    drain();
    repeat (3) begin @(posedge clk); #1; end
    chk("final_queue", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lead_one_scanner.md
# lead_one_scanner

Parametrised, multi-cycle leading/trailing-one scanner for fixed-point vectors, successor to the single-cycle integer-part last-set-bit finder. Scans a WIDTH-bit fixed-point vector CHUNK bits per cycle, from the MSB or the LSB, and terminates early on the first hit. Reports the bit index, the signed exponent relative to the binary point, and the half-exponent used to seed the square-root and normalisation datapaths. Sits between the fixed-point vector registers and the sqrt/normalise units, using a start/ready/done handshake.

## Interface
- WIDTH, 52: vector width in bits, 2 or more.
- FRAC_BITS, 4: number of fractional bits, 0 ≤ FRAC_BITS < WIDTH.
- CHUNK, 8: bits examined per scan cycle, 1 ≤ CHUNK ≤ WIDTH.
- Derived: NCHUNK = ceil(WIDTH/CHUNK); LOC_W = $clog2(WIDTH).
- clk  in  1  the single clock; all logic on its rising edge.
- rst_  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- vec  in  WIDTH  fixed-point operand, sampled on the accept edge.
- mode_lsb  in  1  0 = find the highest set bit, 1 = find the lowest set bit; sampled on the accept edge.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse when results update.
- zero  out  1  vector had no set bit.
- idx  out  LOC_W  bit index of the hit.
- exp  out  LOC_W+1 signed  idx − FRAC_BITS.
- half_exp  out  LOC_W+1 signed  ceil(exp/2) = (exp+1)>>>1.

## Operation
- States: IDLE, SCAN.
- IDLE: ready=1. On start=1, capture vec and mode_lsb, set the chunk pointer, and go to SCAN.
- Pointer start value: NCHUNK−1 in MSB mode, 0 in LSB mode.
- Chunk k covers bits [min(k·CHUNK+CHUNK−1, WIDTH−1) : k·CHUNK]. Pad bits of a partial top chunk read as 0.
- SCAN, each cycle: run a priority encode on the current chunk (highest bit in MSB mode, lowest bit in LSB mode).
  - Hit: register idx, exp, and half_exp; set zero=0; pulse done; return to IDLE.
  - No hit, last chunk (pointer 0 in MSB mode, NCHUNK−1 in LSB mode): register idx=0, exp=−FRAC_BITS, half_exp=(−FRAC_BITS+1)>>>1, zero=1; pulse done; return to IDLE.
  - Otherwise: step the pointer (decrement in MSB mode, increment in LSB mode) and stay in SCAN.
- start while in SCAN is ignored. The captured vec and mode are unaffected.
- idx, exp, half_exp, and zero hold their values until the next done.
- exp and half_exp use two's-complement arithmetic; half_exp rounds toward +∞.

## Timing
- Reset (rst_=1 at an edge): state IDLE, ready=1, done=0, zero=0, idx=0, exp=0, half_exp=0. Reset overrides start and aborts any scan in progress without a done pulse.
- Accept edge E0: start=1 and ready=1. ready drops to 0 in the following cycle.
- Hit in the j-th chunk scanned (j=0 first): results and done become visible after edge E(j+1), so latency is j+1 cycles.
- Zero vector: latency NCHUNK cycles.
- ready=1 in the same cycle that done=1. A start in that cycle is accepted, giving back-to-back operation with no dead cycle.
- done is high for exactly one cycle per accepted request.

## Test plan
Configuration for all scenarios: WIDTH=52, FRAC_BITS=4, CHUNK=8, so NCHUNK=7.
1. vec=1<<51, MSB mode -> done 1 cycle after accept; idx=51, exp=47, half_exp=24, zero=0.
2. Each vector in MSB mode:
   - vec=0x80 -> latency 7; idx=7, exp=3, half_exp=2.
   - vec=0x2 -> idx=1, exp=−3, half_exp=−1.
   - vec=0x1 -> exp=−4, half_exp=−2.
3. vec with bits 3 and 40 set:
   - LSB mode -> latency 1; idx=3, exp=−1, half_exp=0.
   - MSB mode -> latency 2; idx=40.
4. vec=0, both modes -> latency 7; zero=1, idx=0, exp=−4, half_exp=−2; done exactly one cycle.
5. start pulsed during SCAN with a different vec -> ignored; the first result is unchanged. A second start issued in the done cycle is accepted; both results are correct with no gap.
6. rst_ asserted mid-SCAN -> next cycle IDLE, ready=1, all outputs 0, no done pulse. A fresh request afterwards completes normally.
